// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes, functs, ALU codes, mux selects.
// Optional BNE support in the controller is enabled with the MC_BNE_EN macro.
package multicycle_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S_IDLE   = 4'd0;
  localparam state_t S_FETCH  = 4'd1;
  localparam state_t S_DECODE = 4'd2;
  localparam state_t S_MEMADR = 4'd3;
  localparam state_t S_MEMRD  = 4'd4;
  localparam state_t S_MEMWB  = 4'd5;
  localparam state_t S_MEMWR  = 4'd6;
  localparam state_t S_EXEC   = 4'd7;
  localparam state_t S_ALUWB  = 4'd8;
  localparam state_t S_BRANCH = 4'd9;
  localparam state_t S_ADDIEX = 4'd10;
  localparam state_t S_ADDIWB = 4'd11;
  localparam state_t S_JUMP   = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PC_ALURES = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // States that sit on memory and therefore run the wait counter.
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/multicycle_aludec.sv
// ALU-function decoder: maps aluop and funct to the 3-bit ALU code, zero-extended to ALUCTRL_W.
module multicycle_aludec
  import multicycle_pkg::*;
#(
  parameter int ALUCTRL_W = 3
) (
  input  aluop_e               i_aluop,
  input  logic [5:0]           i_funct,
  output logic [ALUCTRL_W-1:0] o_alucontrol,
  output logic                 o_illegal_funct
);

  logic [2:0] w_code;

  always_comb begin
    w_code          = ALU_ADD;
    o_illegal_funct = 1'b0;
    case (i_aluop)
      ALUOP_ADD: w_code = ALU_ADD;
      ALUOP_SUB: w_code = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct)
          FN_ADD:  w_code = ALU_ADD;
          FN_SUB:  w_code = ALU_SUB;
          FN_AND:  w_code = ALU_AND;
          FN_OR:   w_code = ALU_OR;
          FN_SLT:  w_code = ALU_SLT;
          default: begin
            w_code          = ALU_ADD;
            o_illegal_funct = 1'b1;
          end
        endcase
      end
      default: w_code = ALU_ADD;
    endcase
  end

  always_comb begin
    o_alucontrol      = '0;
    o_alucontrol[2:0] = w_code;
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM with memory-wait timeout and PC-enable gating.
// Define MC_BNE_EN to decode BNE (000101) as an inverted-condition branch.
module multicycle_controller
  import multicycle_pkg::*;
#(
  parameter int ALUCTRL_W = 3,
  parameter int TIMEOUT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pcen,
  output logic                 iord,
  output logic                 memread,
  output logic                 memwrite,
  output logic                 irwrite,
  output logic                 regdst,
  output logic                 memtoreg,
  output logic                 regwrite,
  output logic                 alusrca,
  output logic [1:0]           alusrcb,
  output logic [1:0]           pcsrc,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output logic                 illegal_op,
  output logic                 mem_timeout
);

  localparam logic [TIMEOUT_W-1:0] WAIT_LIMIT = '1;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [TIMEOUT_W-1:0]   r_wait_cnt;
  logic                   w_waiting;
  logic                   w_timeout;
  logic                   w_pcwrite;
  logic                   w_branch;
  logic                   w_taken;
  logic                   w_bad_opcode;
  logic                   w_illegal_funct;
  aluop_e                 w_aluop;
  logic [ALUCTRL_W-1:0]   w_alucontrol;

  assign w_waiting = is_wait_state(r_state) && !mem_ready;
  assign w_timeout = w_waiting && (r_wait_cnt == WAIT_LIMIT);

  always_comb begin
    w_next_state = r_state;
    w_pcwrite    = 1'b0;
    w_branch     = 1'b0;
    w_bad_opcode = 1'b0;
    w_aluop      = ALUOP_ADD;
    iord         = 1'b0;
    memread      = 1'b0;
    memwrite     = 1'b0;
    irwrite      = 1'b0;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    regwrite     = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = SRCB_REGB;
    pcsrc        = PC_ALURES;
    case (r_state)
      S_IDLE: w_next_state = S_FETCH;
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = SRCB_FOUR;
        if (mem_ready) begin
          irwrite      = 1'b1;
          w_pcwrite    = 1'b1;
          w_next_state = S_DECODE;
        end else if (w_timeout) begin
          memread      = 1'b0;
          w_next_state = S_IDLE;
        end
      end
      S_DECODE: begin
        alusrcb = SRCB_IMMSH;
        case (opcode)
          OP_LW, OP_SW: w_next_state = S_MEMADR;
          OP_RTYPE:     w_next_state = S_EXEC;
          OP_BEQ:       w_next_state = S_BRANCH;
`ifdef MC_BNE_EN
          OP_BNE:       w_next_state = S_BRANCH;
`endif
          OP_ADDI:      w_next_state = S_ADDIEX;
          OP_J:         w_next_state = S_JUMP;
          default: begin
            w_bad_opcode = 1'b1;
            w_next_state = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca      = 1'b1;
        alusrcb      = SRCB_IMM;
        w_next_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        memread = 1'b1;
        if (mem_ready) begin
          w_next_state = S_MEMWB;
        end else if (w_timeout) begin
          memread      = 1'b0;
          w_next_state = S_IDLE;
        end
      end
      S_MEMWB: begin
        memtoreg     = 1'b1;
        regwrite     = 1'b1;
        w_next_state = S_FETCH;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        if (mem_ready) begin
          w_next_state = S_FETCH;
        end else if (w_timeout) begin
          memwrite     = 1'b0;
          w_next_state = S_IDLE;
        end
      end
      S_EXEC: begin
        alusrca      = 1'b1;
        w_aluop      = ALUOP_FUNCT;
        w_next_state = S_ALUWB;
      end
      S_ALUWB: begin
        regdst       = 1'b1;
        regwrite     = 1'b1;
        w_next_state = S_FETCH;
      end
      S_BRANCH: begin
        alusrca      = 1'b1;
        w_aluop      = ALUOP_SUB;
        pcsrc        = PC_ALUOUT;
        w_branch     = 1'b1;
        w_next_state = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca      = 1'b1;
        alusrcb      = SRCB_IMM;
        w_next_state = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite     = 1'b1;
        w_next_state = S_FETCH;
      end
      S_JUMP: begin
        pcsrc        = PC_JUMP;
        w_pcwrite    = 1'b1;
        w_next_state = S_FETCH;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  multicycle_aludec #(
    .ALUCTRL_W(ALUCTRL_W)
  ) u_aludec (
    .i_aluop        (w_aluop),
    .i_funct        (funct),
    .o_alucontrol   (w_alucontrol),
    .o_illegal_funct(w_illegal_funct)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Counter only advances while a memory state is stalled; any other cycle leaves it at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (w_waiting && !w_timeout) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end else begin
      r_wait_cnt <= '0;
    end
  end

`ifdef MC_BNE_EN
  logic r_is_bne;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_bne <= 1'b0;
    end else if (r_state == S_DECODE) begin
      r_is_bne <= (opcode == OP_BNE);
    end
  end

  assign w_taken = zero ^ r_is_bne;
`else
  assign w_taken = zero;
`endif

  assign pcen        = w_pcwrite | (w_branch & w_taken);
  assign alucontrol  = (r_state == S_IDLE) ? '0 : w_alucontrol;
  assign illegal_op  = w_bad_opcode | ((r_state == S_EXEC) & w_illegal_funct);
  assign mem_timeout = w_timeout;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller (TIMEOUT_W=2); BNE steps follow MC_BNE_EN.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pcen, iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic       illegal_op, mem_timeout;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  multicycle_controller #(
    .ALUCTRL_W(3),
    .TIMEOUT_W(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pcen       (pcen),
    .iord       (iord),
    .memread    (memread),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .regwrite   (regwrite),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .illegal_op (illegal_op),
    .mem_timeout(mem_timeout)
  );

  // {pcen,iord,memread,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,pcsrc,alucontrol,illegal_op,mem_timeout}
  logic [17:0] w_obs;
  assign w_obs = {pcen, iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite,
                  alusrca, alusrcb, pcsrc, alucontrol, illegal_op, mem_timeout};

  localparam logic [17:0] MK_FULL = 18'h3FFFF;
  localparam logic [17:0] MK_EN   = 18'h2E403;
  localparam logic [17:0] MK_IORD = 18'h10000;
  localparam logic [17:0] MK_RDM  = 18'h01800;
  localparam logic [17:0] MK_ALU  = 18'h0039C;
  localparam logic [17:0] MK_PCS  = 18'h00060;
  localparam logic [17:0] MK_MRD  = 18'h08000;

  function automatic logic [17:0] v(input logic pc, io, mr, mw, ir, rd, mt, rw, sa,
                                    input logic [1:0] sb, ps, input logic [2:0] al,
                                    input logic il, to);
    return {pc, io, mr, mw, ir, rd, mt, rw, sa, sb, ps, al, il, to};
  endfunction

  task automatic chk(input string tag, input logic [17:0] exp, input logic [17:0] msk);
    vectors++;
    assert ((w_obs & msk) === (exp & msk))
    else begin
      miscompares++;
      $error("FAIL %s: observed %05h required %05h (mask %05h)", tag, w_obs & msk, exp & msk, msk);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [17:0] e_fetch, e_fwait, e_dec, e_dec_ill, e_memadr, e_memrd, e_memwb, e_memwr;
  logic [17:0] e_exec_slt, e_exec_bad, e_aluwb, e_br_t, e_br_n, e_addiex, e_addiwb, e_jump, e_tmo;
  logic [17:0] m_fetch, m_alu, m_mem, m_wb, m_br, m_jump;

  initial begin
    e_fetch    = v(1,0,1,0,1,0,0,0,0,2'b01,2'b00,3'b010,0,0);
    e_fwait    = v(0,0,1,0,0,0,0,0,0,2'b01,2'b00,3'b010,0,0);
    e_dec      = v(0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0,0);
    e_dec_ill  = v(0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,1,0);
    e_memadr   = v(0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0,0);
    e_memrd    = v(0,1,1,0,0,0,0,0,0,2'b00,2'b00,3'b000,0,0);
    e_memwb    = v(0,0,0,0,0,0,1,1,0,2'b00,2'b00,3'b000,0,0);
    e_memwr    = v(0,1,0,1,0,0,0,0,0,2'b00,2'b00,3'b000,0,0);
    e_exec_slt = v(0,0,0,0,0,0,0,0,1,2'b00,2'b00,3'b111,0,0);
    e_exec_bad = v(0,0,0,0,0,0,0,0,1,2'b00,2'b00,3'b010,1,0);
    e_aluwb    = v(0,0,0,0,0,1,0,1,0,2'b00,2'b00,3'b000,0,0);
    e_br_t     = v(1,0,0,0,0,0,0,0,1,2'b00,2'b01,3'b110,0,0);
    e_br_n     = v(0,0,0,0,0,0,0,0,1,2'b00,2'b01,3'b110,0,0);
    e_addiex   = v(0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0,0);
    e_addiwb   = v(0,0,0,0,0,0,0,1,0,2'b00,2'b00,3'b000,0,0);
    e_jump     = v(1,0,0,0,0,0,0,0,0,2'b00,2'b10,3'b000,0,0);
    e_tmo      = v(0,0,0,0,0,0,0,0,0,2'b01,2'b00,3'b010,0,1);
    m_fetch    = MK_EN | MK_IORD | MK_ALU | MK_PCS;
    m_alu      = MK_EN | MK_ALU;
    m_mem      = MK_EN | MK_IORD;
    m_wb       = MK_EN | MK_RDM;
    m_br       = MK_EN | MK_ALU | MK_PCS;
    m_jump     = MK_EN | MK_PCS;

    rst_n = 1'b0; opcode = 6'b0; funct = 6'b0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) tick();
    chk("reset_idle", 18'h0, MK_FULL);

    // LW with memory always ready: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB
    rst_n = 1'b1; opcode = 6'b100011; mem_ready = 1'b1;
    #1 chk("idle_after_release", 18'h0, MK_FULL);
    tick(); #1 chk("lw_fetch", e_fetch, m_fetch);
    tick(); #1 chk("lw_decode", e_dec, m_alu);
    tick(); #1 chk("lw_memadr", e_memadr, m_alu);
    tick(); #1 chk("lw_memrd", e_memrd, m_mem);
    tick(); #1 chk("lw_memwb", e_memwb, m_wb);

    // R-type SLT, then an undecodable funct
    tick(); opcode = 6'b000000; funct = 6'b101010;
    #1 chk("r_fetch", e_fetch, m_fetch);
    tick();
    tick(); #1 chk("r_exec_slt", e_exec_slt, m_alu);
    tick(); #1 chk("r_aluwb", e_aluwb, m_wb);
    tick(); funct = 6'b111111;
    tick();
    tick(); #1 chk("r_exec_badfunct", e_exec_bad, m_alu);
    tick(); #1 chk("r_aluwb_after_bad", e_aluwb, m_wb);

    // BEQ taken and not taken
    tick(); opcode = 6'b000100; zero = 1'b1;
    tick();
    tick(); #1 chk("beq_taken", e_br_t, m_br);
    tick(); zero = 1'b0;
    tick();
    tick(); #1 chk("beq_not_taken", e_br_n, m_br);
    tick();

`ifdef MC_BNE_EN
    opcode = 6'b000101; zero = 1'b1;
    tick();
    tick(); #1 chk("bne_zero1", e_br_n, m_br);
    tick(); zero = 1'b0;
    tick();
    tick(); #1 chk("bne_zero0", e_br_t, m_br);
    tick();
`else
    opcode = 6'b000101;
    tick(); #1 chk("bne_illegal", e_dec_ill, m_alu);
    tick(); #1 chk("bne_back_to_fetch", e_fetch, m_fetch);
`endif

    // ADDI and J
    opcode = 6'b001000; zero = 1'b0;
    tick();
    tick(); #1 chk("addi_exec", e_addiex, m_alu);
    tick(); #1 chk("addi_wb", e_addiwb, m_wb);
    tick(); opcode = 6'b000010;
    tick();
    tick(); #1 chk("j_jump", e_jump, m_jump);
    tick(); #1 chk("j_to_fetch", e_fetch, m_fetch);

    // SW stalled three cycles; ready arrives exactly at the count limit
    opcode = 6'b101011;
    tick();
    tick(); mem_ready = 1'b0;
    tick(); #1 chk("sw_wait0", e_memwr, m_mem);
    tick(); #1 chk("sw_wait1", e_memwr, m_mem);
    tick(); #1 chk("sw_wait2", e_memwr, m_mem);
    tick(); mem_ready = 1'b1;
    #1 chk("sw_ready_at_limit", e_memwr, m_mem);
    tick(); #1 chk("sw_to_fetch", e_fetch, m_fetch);

    // Illegal opcode in DECODE
    opcode = 6'b111111;
    tick(); #1 chk("illop_decode", e_dec_ill, m_alu);
    tick(); #1 chk("illop_to_fetch", e_fetch, m_fetch);

    // Memory stuck in FETCH: timeout after three wait cycles, then IDLE, then FETCH
    mem_ready = 1'b0;
    #1 chk("fetch_wait0", e_fwait, m_fetch);
    tick(); #1 chk("fetch_wait1", e_fwait, m_fetch);
    tick(); #1 chk("fetch_wait2", e_fwait, m_fetch);
    tick(); #1 chk("fetch_timeout", e_tmo, m_fetch & ~MK_MRD);
    tick(); #1 chk("timeout_idle", 18'h0, MK_FULL);
    tick(); #1 chk("timeout_retry_fetch", e_fwait, m_fetch);

    // Asynchronous reset while stalled in MEMRD
    opcode = 6'b100011; mem_ready = 1'b1;
    tick();
    tick(); mem_ready = 1'b0;
    tick(); #1 chk("memrd_stalled", e_memrd, m_mem);
    rst_n = 1'b0;
    #1 chk("async_reset_idle", 18'h0, MK_FULL);
    tick(); #1 chk("reset_hold_idle", 18'h0, MK_FULL);
    rst_n = 1'b1; mem_ready = 1'b1;
    tick(); #1 chk("post_reset_fetch", e_fetch, m_fetch);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
